// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants and state encoding for the instruction fetch stage
//
// Contents:
//   FU_PC_LEN, FU_INSTR_LEN : default address / instruction byte widths
//   FU_NOP_INSTR            : default bubble byte shown to the decoder
//   LB5                     : 5-bit major opcode of the two-byte load-byte instruction
//   fetch_state_t           : 3-bit fetch/issue FSM encoding
package fetch_unit_pkg;

    localparam int         FU_PC_LEN    = 7;
    localparam int         FU_INSTR_LEN = 8;
    localparam logic [7:0] FU_NOP_INSTR = 8'h00;
    localparam logic [4:0] LB5          = 5'b11100;

    typedef enum logic [2:0] {
        FETCH0 = 3'd0,
        FETCH1 = 3'd1,
        ISSUE0 = 3'd2,
        ISSUE1 = 3'd3,
        HALT   = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// rtl/fetch_unit_pc_next.sv - combinational next-PC select and self-branch compare
//
// Ports:
//   pc         in   current program counter
//   br_target  in   decoder branch target
//   take_br    in   branch is being taken on this issue edge
//   skip2      in   advance past a two-byte instruction
//   pc_plus1   out  pc+1 (also the address of an LB immediate)
//   pc_next    out  selected next PC
//   self_br    out  branch target equals the current PC
module fetch_unit_pc_next #(
    parameter int PC_LEN = 7
) (
    input  logic [PC_LEN-1:0] pc,
    input  logic [PC_LEN-1:0] br_target,
    input  logic              take_br,
    input  logic              skip2,
    output logic [PC_LEN-1:0] pc_plus1,
    output logic [PC_LEN-1:0] pc_next,
    output logic              self_br
);

    // Additions wrap naturally at PC_LEN bits, so 127+1=0 and 127+2=1.
    assign pc_plus1 = pc + PC_LEN'(1);
    assign self_br  = (br_target == pc);

    always_comb begin
        pc_next = pc_plus1;
        if (take_br) begin
            pc_next = br_target;
        end else if (skip2) begin
            pc_next = pc + PC_LEN'(2);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem handshake, LB pre-fetch, branch redirect, halt
//
// Ports:
//   CLK, RSTN            clock, asynchronous active-low reset
//   IMEM_REQ/IMEM_ADDR   instruction memory request and address (held until IMEM_VALID)
//   IMEM_RDATA/VALID     instruction memory response
//   INSTR/INSTR_VALID    byte issued to the decoder, one cycle per byte
//   IS_BR/BR_TARGET      decoder branch flag and target for the byte on INSTR
//   BR_COND              branch condition from execute
//   STALL                downstream hold, honoured only before the first byte issues
//   PC                   address of the instruction currently fetching or issuing
//   HALTED               self-branch detected; left only through reset
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                   PC_LEN    = FU_PC_LEN,
    parameter int                   INSTR_LEN = FU_INSTR_LEN,
    parameter logic [PC_LEN-1:0]    RESET_PC  = '0,
    parameter logic [INSTR_LEN-1:0] NOP_INSTR = FU_NOP_INSTR
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    output logic                 IMEM_REQ,
    output logic [PC_LEN-1:0]    IMEM_ADDR,
    input  logic [INSTR_LEN-1:0] IMEM_RDATA,
    input  logic                 IMEM_VALID,
    output logic [INSTR_LEN-1:0] INSTR,
    output logic                 INSTR_VALID,
    input  logic                 IS_BR,
    input  logic [PC_LEN-1:0]    BR_TARGET,
    input  logic                 BR_COND,
    input  logic                 STALL,
    output logic [PC_LEN-1:0]    PC,
    output logic                 HALTED
);

    fetch_state_t         state;
    logic [PC_LEN-1:0]    pc;
    logic [INSTR_LEN-1:0] byte0;
    logic [INSTR_LEN-1:0] byte1;
    logic                 imem_req_q;
    logic [INSTR_LEN-1:0] instr_q;
    logic                 instr_valid_q;
    logic                 halted_q;

    logic                 take_br;
    logic                 skip2;
    logic [PC_LEN-1:0]    pc_plus1;
    logic [PC_LEN-1:0]    pc_next;
    logic                 self_br;
    logic                 rdata_is_lb;
    logic                 byte0_is_lb;

    assign rdata_is_lb = (IMEM_RDATA[INSTR_LEN-1 -: 5] == LB5);
    assign byte0_is_lb = (byte0[INSTR_LEN-1 -: 5] == LB5);

    // Branch flags only matter on the edge where byte0 of a non-LB is on INSTR.
    assign take_br = (state == ISSUE0) && IS_BR && BR_COND;
    assign skip2   = (state == ISSUE1);

    fetch_unit_pc_next #(
        .PC_LEN (PC_LEN)
    ) u_pc_next (
        .pc        (pc),
        .br_target (BR_TARGET),
        .take_br   (take_br),
        .skip2     (skip2),
        .pc_plus1  (pc_plus1),
        .pc_next   (pc_next),
        .self_br   (self_br)
    );

    assign IMEM_REQ    = imem_req_q;
    assign IMEM_ADDR   = (state == FETCH1) ? pc_plus1 : pc;
    assign INSTR       = instr_q;
    assign INSTR_VALID = instr_valid_q;
    assign PC          = pc;
    assign HALTED      = halted_q;

    // In ISSUE0, instr_valid_q doubles as the "byte0 already on INSTR" flag:
    // low means we are in the pre-issue STALL hold.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state         <= FETCH0;
            pc            <= RESET_PC;
            byte0         <= '0;
            byte1         <= '0;
            imem_req_q    <= 1'b0;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            case (state)
                FETCH0: begin
                    if (!imem_req_q) begin
                        // First cycle out of reset: raise the request, ignore any stray VALID.
                        imem_req_q <= 1'b1;
                    end else if (IMEM_VALID) begin
                        byte0 <= IMEM_RDATA;
                        if (rdata_is_lb) begin
                            // Keep REQ high; the address moves to pc+1 for the immediate.
                            state <= FETCH1;
                        end else begin
                            imem_req_q <= 1'b0;
                            state      <= ISSUE0;
                            if (!STALL) begin
                                instr_q       <= IMEM_RDATA;
                                instr_valid_q <= 1'b1;
                            end
                        end
                    end
                end

                FETCH1: begin
                    if (IMEM_VALID) begin
                        byte1      <= IMEM_RDATA;
                        imem_req_q <= 1'b0;
                        state      <= ISSUE0;
                        if (!STALL) begin
                            instr_q       <= byte0;
                            instr_valid_q <= 1'b1;
                        end
                    end
                end

                ISSUE0: begin
                    if (!instr_valid_q) begin
                        if (!STALL) begin
                            instr_q       <= byte0;
                            instr_valid_q <= 1'b1;
                        end
                    end else if (byte0_is_lb) begin
                        // Immediate follows back-to-back; the decoder cannot tolerate a gap.
                        instr_q <= byte1;
                        state   <= ISSUE1;
                    end else begin
                        instr_q       <= NOP_INSTR;
                        instr_valid_q <= 1'b0;
                        if (take_br && self_br) begin
                            halted_q <= 1'b1;
                            state    <= HALT;
                        end else begin
                            pc         <= pc_next;
                            imem_req_q <= 1'b1;
                            state      <= FETCH0;
                        end
                    end
                end

                ISSUE1: begin
                    instr_q       <= NOP_INSTR;
                    instr_valid_q <= 1'b0;
                    pc            <= pc_next;
                    imem_req_q    <= 1'b1;
                    state         <= FETCH0;
                end

                HALT: begin
                    imem_req_q    <= 1'b0;
                    instr_q       <= NOP_INSTR;
                    instr_valid_q <= 1'b0;
                    halted_q      <= 1'b1;
                end

                default: begin
                    state <= FETCH0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a variable-latency memory and decoder model
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [7:0] LB_OP = {LB5, 3'b000};

    logic       CLK = 1'b0;
    logic       RSTN;
    logic       IMEM_REQ;
    logic [6:0] IMEM_ADDR;
    logic [7:0] IMEM_RDATA = 8'h00;
    logic       IMEM_VALID = 1'b0;
    logic [7:0] INSTR;
    logic       INSTR_VALID;
    logic       IS_BR = 1'b0;
    logic [6:0] BR_TARGET = 7'd0;
    logic       BR_COND = 1'b0;
    logic       STALL = 1'b0;
    logic [6:0] PC;
    logic       HALTED;

    always #5 CLK = ~CLK;

    fetch_unit dut (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_RDATA  (IMEM_RDATA),
        .IMEM_VALID  (IMEM_VALID),
        .INSTR       (INSTR),
        .INSTR_VALID (INSTR_VALID),
        .IS_BR       (IS_BR),
        .BR_TARGET   (BR_TARGET),
        .BR_COND     (BR_COND),
        .STALL       (STALL),
        .PC          (PC),
        .HALTED      (HALTED)
    );

    logic [7:0]  mem     [128];
    logic        br_is   [128];
    logic [6:0]  br_tgt  [128];
    logic        br_cond [128];
    int          lat = 0;
    int          wait_cnt = 0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [6:0]  exp_fetch [$];
    logic [14:0] exp_issue [$];
    int          issue_cyc [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory responder, decoder model and scoreboard; all act on the falling edge.
    always @(negedge CLK) begin
        logic [14:0] e;
        cyc++;
        if (!RSTN || !IMEM_REQ) begin
            IMEM_VALID = 1'b0;
            wait_cnt   = 0;
        end else begin
            if (IMEM_VALID) wait_cnt = 0;
            if (wait_cnt >= lat) begin
                IMEM_VALID = 1'b1;
                IMEM_RDATA = mem[IMEM_ADDR];
            end else begin
                IMEM_VALID = 1'b0;
                wait_cnt++;
            end
        end
        IS_BR     = INSTR_VALID && br_is[PC];
        BR_TARGET = br_tgt[PC];
        BR_COND   = br_cond[PC];
        if (RSTN && IMEM_REQ && IMEM_VALID && exp_fetch.size() > 0)
            chk("fetch_addr", 32'(IMEM_ADDR), 32'(exp_fetch.pop_front()));
        if (RSTN && INSTR_VALID && exp_issue.size() > 0) begin
            e = exp_issue.pop_front();
            chk("issue_instr", 32'(INSTR), 32'(e[7:0]));
            chk("issue_pc", 32'(PC), 32'(e[14:8]));
            issue_cyc.push_back(cyc);
        end
    end

    task automatic do_reset();
        RSTN  = 1'b0;
        STALL = 1'b0;
        repeat (2) @(negedge CLK);
        exp_fetch.delete();
        exp_issue.delete();
        issue_cyc.delete();
        for (int i = 0; i < 128; i++) begin
            mem[i]     = 8'h01;
            br_is[i]   = 1'b0;
            br_tgt[i]  = 7'd0;
            br_cond[i] = 1'b0;
        end
    endtask

    task automatic set_br(input int at, input int tgt, input logic cond);
        br_is[at]   = 1'b1;
        br_tgt[at]  = 7'(tgt);
        br_cond[at] = cond;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((exp_fetch.size() != 0 || exp_issue.size() != 0) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_drain"}, 32'(exp_fetch.size() + exp_issue.size()), 32'd0);
    endtask

    function automatic logic [31:0] gap(input int a, input int b);
        if (issue_cyc.size() > b) return 32'(issue_cyc[b] - issue_cyc[a]);
        return 32'hFFFF_FFFF;
    endfunction

    initial begin
        RSTN = 1'b0;

        // Reset state and plain back-to-back instructions, zero-wait memory
        do_reset();
        chk("rst_req", 32'(IMEM_REQ), 32'd0);
        chk("rst_valid", 32'(INSTR_VALID), 32'd0);
        chk("rst_instr", 32'(INSTR), 32'(FU_NOP_INSTR));
        chk("rst_halted", 32'(HALTED), 32'd0);
        chk("rst_pc", 32'(PC), 32'd0);
        mem[0] = 8'h12;
        mem[1] = 8'h23;
        lat = 0;
        exp_fetch = '{7'd0, 7'd1};
        exp_issue = '{{7'd0, 8'h12}, {7'd1, 8'h23}};
        RSTN = 1'b1;
        @(negedge CLK);
        chk("req_first_edge", 32'(IMEM_REQ), 32'd1);
        drain("plain", 40);
        chk("plain_gap", gap(0, 1), 32'd2);

        // LB at 5 with latency 3, reached by a branch from 0
        do_reset();
        mem[0] = 8'h30;
        set_br(0, 5, 1'b1);
        mem[5] = LB_OP;
        mem[6] = 8'hA7;
        lat = 3;
        exp_fetch = '{7'd0, 7'd5, 7'd6, 7'd7};
        exp_issue = '{{7'd0, 8'h30}, {7'd5, LB_OP}, {7'd5, 8'hA7}};
        RSTN = 1'b1;
        drain("lb", 100);
        chk("lb_gap", gap(1, 2), 32'd1);

        // Branch at 10 to 40, taken then not taken
        for (int c = 0; c < 2; c++) begin
            do_reset();
            set_br(0, 10, 1'b1);
            set_br(10, 40, c == 0);
            lat = 1;
            exp_fetch = '{7'd0, 7'd10, (c == 0) ? 7'd40 : 7'd11};
            exp_issue = '{{7'd0, 8'h01}, {7'd10, 8'h01}};
            RSTN = 1'b1;
            drain(c == 0 ? "br_taken" : "br_not_taken", 60);
        end

        // STALL before an ordinary issue, then STALL during ISSUE1
        do_reset();
        STALL = 1'b1;
        mem[0] = 8'h55;
        mem[1] = LB_OP;
        mem[2] = 8'h9C;
        lat = 0;
        exp_fetch = '{7'd0, 7'd1, 7'd2, 7'd3};
        exp_issue = '{{7'd0, 8'h55}, {7'd1, LB_OP}, {7'd1, 8'h9C}};
        RSTN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("stall_hold_valid", 32'(INSTR_VALID), 32'd0);
            chk("stall_hold_instr", 32'(INSTR), 32'(FU_NOP_INSTR));
        end
        STALL = 1'b0;
        @(negedge CLK);
        chk("stall_release_valid", 32'(INSTR_VALID), 32'd1);
        chk("stall_release_instr", 32'(INSTR), 32'h55);
        begin
            int n = 0;
            while (!(INSTR_VALID && INSTR == LB_OP) && n < 40) begin
                @(negedge CLK);
                n++;
            end
            chk("stall_lb_seen", 32'(n < 40), 32'd1);
        end
        STALL = 1'b1;
        @(negedge CLK);
        chk("stall_issue1_valid", 32'(INSTR_VALID), 32'd1);
        chk("stall_issue1_instr", 32'(INSTR), 32'h9C);
        drain("stall", 40);
        STALL = 1'b0;

        // Wrap: LB at 127 takes its immediate from 0, then plain at 127
        do_reset();
        mem[0] = 8'h30;
        set_br(0, 127, 1'b1);
        mem[127] = LB_OP;
        lat = 0;
        exp_fetch = '{7'd0, 7'd127, 7'd0, 7'd1};
        exp_issue = '{{7'd0, 8'h30}, {7'd127, LB_OP}, {7'd127, 8'h30}};
        RSTN = 1'b1;
        drain("wrap_lb", 60);

        do_reset();
        mem[0] = 8'h30;
        set_br(0, 127, 1'b1);
        mem[127] = 8'h44;
        lat = 0;
        exp_fetch = '{7'd0, 7'd127, 7'd0};
        exp_issue = '{{7'd0, 8'h30}, {7'd127, 8'h44}};
        RSTN = 1'b1;
        drain("wrap_plain", 60);

        // Self-branch halt at 20, then reset out of HALT and reset mid-fetch
        do_reset();
        mem[0] = 8'h30;
        set_br(0, 20, 1'b1);
        set_br(20, 20, 1'b1);
        lat = 2;
        exp_fetch = '{7'd0, 7'd20};
        exp_issue = '{{7'd0, 8'h30}, {7'd20, 8'h01}};
        RSTN = 1'b1;
        drain("halt", 60);
        repeat (2) @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("halt_flag", 32'(HALTED), 32'd1);
            chk("halt_req", 32'(IMEM_REQ), 32'd0);
            chk("halt_valid", 32'(INSTR_VALID), 32'd0);
        end
        #2 RSTN = 1'b0;
        #1;
        chk("halt_rst_halted", 32'(HALTED), 32'd0);
        chk("halt_rst_pc", 32'(PC), 32'd0);
        chk("halt_rst_req", 32'(IMEM_REQ), 32'd0);
        lat = 6;
        @(negedge CLK);
        RSTN = 1'b1;
        @(negedge CLK);
        chk("resume_req", 32'(IMEM_REQ), 32'd1);
        chk("resume_addr", 32'(IMEM_ADDR), 32'd0);
        #2 RSTN = 1'b0;
        #1;
        chk("midfetch_rst_req", 32'(IMEM_REQ), 32'd0);
        @(negedge CLK);
        RSTN = 1'b1;
        repeat (2) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the 8-bit simple core; sits directly upstream of the instruction decoder and drives its INSTR input.
- Owns the PC and issues requests to an instruction memory with a variable-latency req/valid handshake.
- Presents each instruction to the decoder for exactly one cycle. Pre-fetches the immediate byte of a two-byte load-byte (LB) instruction so the pair issues back-to-back.
- Redirects the PC on taken branches and detects the self-branch halt idiom.

Parameters:
PC_LEN, 7, program counter / instruction address width
INSTR_LEN, 8, instruction byte width
RESET_PC, 0, PC value loaded on reset
NOP_INSTR, 8'h00, bubble value driven on INSTR when no instruction is issued

Ports:
CLK  in  1  clock
RSTN  in  1  asynchronous active-low reset
IMEM_REQ  out  1  instruction memory request, held until IMEM_VALID
IMEM_ADDR  out  PC_LEN  instruction memory address, stable while IMEM_REQ=1
IMEM_RDATA  in  INSTR_LEN  read data, qualified by IMEM_VALID
IMEM_VALID  in  1  read data valid, accepted only while IMEM_REQ=1
INSTR  out  INSTR_LEN  instruction byte to decoder, NOP_INSTR when INSTR_VALID=0
INSTR_VALID  out  1  INSTR carries a real instruction byte this cycle
IS_BR  in  1  decoder branch flag for the byte currently on INSTR
BR_TARGET  in  PC_LEN  decoder branch target
BR_COND  in  1  branch condition from execute (1 = take branch)
STALL  in  1  downstream hold request, honoured only at instruction boundaries
PC  out  PC_LEN  address of the instruction (first byte) currently issuing or fetching
HALTED  out  1  core halted on self-branch

Behaviour:
- Reset (asynchronous, RSTN=0): state=FETCH0, pc=RESET_PC, IMEM_REQ=0, INSTR=NOP_INSTR, INSTR_VALID=0, HALTED=0, immediate buffer cleared.
- IMEM_REQ is a registered output. It first rises on the first clock edge after reset release.
- States: FETCH0, FETCH1, ISSUE0, ISSUE1, HALT.
- FETCH0: IMEM_REQ=1, IMEM_ADDR=pc. On an edge with IMEM_VALID=1:
  - capture byte0 = IMEM_RDATA.
  - If byte0[7:3]==LB5, go to FETCH1 with IMEM_ADDR=pc+1.
  - Otherwise go to ISSUE0.
- FETCH1: on IMEM_VALID=1, capture byte1 and go to ISSUE0.
- ISSUE0: IMEM_REQ=0, INSTR=byte0, INSTR_VALID=1 for exactly one cycle.
  - If STALL=1 on entry, remain in a pre-issue hold with INSTR=NOP_INSTR and INSTR_VALID=0 until STALL=0.
  - STALL is sampled only before byte0 issues.
  - For LB, go to ISSUE1 unconditionally.
  - Otherwise resolve the branch on the issue edge:
    - IS_BR & BR_COND: if BR_TARGET==pc, go to HALT. Else pc<=BR_TARGET and go to FETCH0.
    - Not taken: pc<=pc+1, go to FETCH0.
- ISSUE1: INSTR=byte1, INSTR_VALID=1, STALL ignored (the decoder's LB tracking cannot be held). Then pc<=pc+2, go to FETCH0.
- IS_BR is ignored in ISSUE1; the decoder masks it anyway.
- PC arithmetic is modulo 2^PC_LEN: 127+1=0, 127+2=1, 126+2=0. LB at 127 fetches its immediate from address 0.
- Minimum throughput with zero-wait memory (IMEM_VALID=1 on the first REQ cycle):
  - plain instruction: 1 fetch + 1 issue = 2 cycles.
  - LB: 4 cycles.
- HALT: INSTR_VALID=0, IMEM_REQ=0, HALTED=1. Exit only by reset.
- IMEM_VALID while IMEM_REQ=0 is ignored.
- Reset mid-fetch drops IMEM_REQ immediately. The memory must tolerate an abandoned request.

Decomposition:
- params.v holds PC_LEN, INSTR_LEN, DATA_LEN, LB5 opcode, NOP encoding, and state encodings (3-bit: FETCH0, FETCH1, ISSUE0, ISSUE1, HALT).
- Optional sub-module fetch_pc_next: combinational next-PC select (pc+1, pc+2, BR_TARGET) with the halt compare. Everything else stays flat.

Test Plan:
- Reset release, zero-wait memory with mem[0]=8'h12, mem[1]=8'h23 -> IMEM_ADDR 0 then 1; INSTR_VALID pulses two cycles apart carrying 12 and 23; PC 0 then 1.
- LB at addr 5 ({LB5,3'b000}), immediate 8'hA7 at 6, memory latency 3 -> two fetches (addr 5, addr 6); INSTR shows LB then A7 on consecutive cycles; next fetch at addr 7.
- Branch at pc 10 with IS_BR=1, BR_TARGET=40, BR_COND=1 -> next IMEM_ADDR=40. Same with BR_COND=0 -> next IMEM_ADDR=11.
- STALL=1 for 3 cycles before an ordinary issue -> INSTR_VALID stays 0 and INSTR=NOP_INSTR; issue happens on the cycle after STALL drops. STALL asserted during ISSUE1 -> byte1 still issues.
- Wrap: LB at pc 127 -> immediate fetched from 0, next PC=1. Plain instruction at 127 -> next PC=0.
- Self-branch at pc 20 (BR_TARGET=20, taken) -> HALTED=1 and IMEM_REQ=0 indefinitely. Assert RSTN=0 mid-HALT -> HALTED=0, PC=RESET_PC, fetch resumes.
